// File: rtl/tile_reshuffle_unit.sv
// Tile permutation stage: registers one NxN tile per accept, applying a row/column/transpose
// rotation whose step advances per tile within a frame and resets at frame end.
module tile_reshuffle_unit #(
    parameter int N         = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_TILES = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [1:0]                              cfg_mode,
    input  logic [$clog2(N)-1:0]                    cfg_step_inc,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic signed [0:N-1][0:N-1][WIDTH-1:0]   in_patch,
    input  logic                                    in_last,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic signed [0:N-1][0:N-1][WIDTH-1:0]   out_patch,
    output logic                                    out_last,
    output logic [$clog2(N)-1:0]                    out_step,
    output logic                                    frame_err
);

    // state  | meaning
    // IDLE   | between frames; next accept latches cfg_* and uses step 0
    // ACTIVE | inside a frame; latched mode/step_inc apply, step advances per accept

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(MAX_TILES + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [SW-1:0]   inc_q, inc_d;
    logic            err_set;

    logic            accept;
    logic [1:0]      mode_cur;
    logic [SW-1:0]   inc_cur;
    logic [SW-1:0]   s_cur;
    logic signed [0:N-1][0:N-1][WIDTH-1:0] perm;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            inc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            inc_q   <= inc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        inc_d    = inc_q;
        err_set  = 1'b0;
        mode_cur = mode_q;
        inc_cur  = inc_q;
        s_cur    = step_q;

        // The first tile of a frame sees live cfg and step 0 in the same cycle it latches.
        if (state_q == IDLE) begin
            mode_cur = cfg_mode;
            inc_cur  = cfg_step_inc;
            s_cur    = '0;
        end

        if (accept) begin
            if (state_q == IDLE) begin
                mode_d = cfg_mode;
                inc_d  = cfg_step_inc;
            end
            if (in_last) begin
                state_d = IDLE;
                step_d  = '0;
                cnt_d   = '0;
            end else if (cnt_q == CW'(MAX_TILES)) begin
                err_set = 1'b1;
                state_d = IDLE;
                step_d  = '0;
                cnt_d   = '0;
            end else begin
                state_d = ACTIVE;
                step_d  = s_cur + inc_cur;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // Power-of-two N lets the rotation index wrap in SW-bit arithmetic.
    always_comb begin
        logic [SW-1:0] rs;
        logic [SW-1:0] cs;
        perm = '0;
        rs   = '0;
        cs   = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                rs = SW'(r) + s_cur;
                cs = SW'(c) + s_cur;
                case (mode_cur)
                    2'd0:    perm[r][c] = in_patch[r][c];
                    2'd1:    perm[r][c] = in_patch[rs][c];
                    2'd2:    perm[r][c] = in_patch[r][cs];
                    default: perm[r][c] = in_patch[cs][r];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_patch <= '0;
            out_last  <= 1'b0;
            out_step  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_patch <= perm;
                out_last  <= in_last;
                out_step  <= s_cur;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (err_set) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tile_reshuffle_unit.sv
// Directed bench for tile_reshuffle_unit: hand-computed tile values, steps and flags.
module tb_tile_reshuffle_unit;

    localparam int N         = 4;
    localparam int WIDTH     = 32;
    localparam int MAX_TILES = 4;
    localparam int SW        = $clog2(N);

    logic                              clk;
    logic                              rst;
    logic [1:0]                        cfg_mode;
    logic [SW-1:0]                     cfg_step_inc;
    logic                              in_valid;
    logic                              in_ready;
    logic [0:N-1][0:N-1][WIDTH-1:0]    in_patch;
    logic                              in_last;
    logic                              out_valid;
    logic                              out_ready;
    logic [0:N-1][0:N-1][WIDTH-1:0]    out_patch;
    logic                              out_last;
    logic [SW-1:0]                     out_step;
    logic                              frame_err;

    int n_cmp = 0;
    int n_err = 0;

    tile_reshuffle_unit #(.N(N), .WIDTH(WIDTH), .MAX_TILES(MAX_TILES)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_mode     (cfg_mode),
        .cfg_step_inc (cfg_step_inc),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_patch     (in_patch),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_patch    (out_patch),
        .out_last     (out_last),
        .out_step     (out_step),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tile pattern: element [r][c] = base + 10r + c
    task automatic drive(input logic [1:0] m, input logic [SW-1:0] inc, input logic last,
                         input int base);
        in_valid     = 1'b1;
        cfg_mode     = m;
        cfg_step_inc = inc;
        in_last      = last;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                in_patch[r][c] = WIDTH'(base + 10 * r + c);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        out_ready    = 1'b0;
        in_patch     = '0;
        drive(2'd1, 2'd1, 1'b0, 500);
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_step", out_step, 0);
        chk("rst_out_patch", out_patch[1][1], 0);
        chk("rst_frame_err", frame_err, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        idle_in();
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        tick();
        chk("rst_tile_dropped", out_valid, 0);

        // Row rotate, step_inc 1, four tiles
        for (int i = 0; i < 4; i++) begin
            drive(2'd1, 2'd1, (i == 3), 0);
            tick();
            chk("r030_valid", out_valid, 1);
            chk("r030_step", out_step, i);
            chk("r030_row0_c0", out_patch[0][0], 10 * i);
            chk("r030_last", out_last, (i == 3));
            if (i == 2)
                for (int c = 0; c < N; c++)
                    chk("r030_t2_row0", out_patch[0][c], 20 + c);
        end
        idle_in();
        tick();
        chk("r030_drain", out_valid, 0);

        // Transpose rotate, step_inc 2
        drive(2'd3, 2'd2, 1'b0, 0);
        tick();
        chk("r031_t0_step", out_step, 0);
        chk("r031_t0_01", out_patch[0][1], 10);
        chk("r031_t0_23", out_patch[2][3], 32);
        drive(2'd3, 2'd2, 1'b1, 0);
        tick();
        chk("r031_t1_step", out_step, 2);
        chk("r031_t1_01", out_patch[0][1], 30);
        chk("r031_t1_23", out_patch[2][3], 12);
        idle_in();
        tick();

        // Backpressure: three stalled cycles then full rate
        drive(2'd0, 2'd1, 1'b0, 100);
        tick();
        chk("r032_a_val", out_patch[0][0], 100);
        chk("r032_a_step", out_step, 0);
        out_ready = 1'b0;
        drive(2'd0, 2'd1, 1'b0, 200);
        #1;
        chk("r032_in_ready_low", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("r032_stall_valid", out_valid, 1);
            chk("r032_stall_patch", out_patch[1][2], 112);
            chk("r032_stall_step", out_step, 0);
            chk("r032_stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("r032_in_ready_high", in_ready, 1);
        tick();
        chk("r032_b_val", out_patch[0][0], 200);
        chk("r032_b_step", out_step, 1);
        drive(2'd0, 2'd1, 1'b1, 300);
        tick();
        chk("r032_c_val", out_patch[0][0], 300);
        chk("r032_c_step", out_step, 2);
        chk("r032_c_last", out_last, 1);
        idle_in();
        tick();
        chk("r032_drain", out_valid, 0);

        // cfg_mode change mid-frame is ignored until the next frame
        drive(2'd1, 2'd1, 1'b0, 0);
        tick();
        chk("r033_f1t0_step", out_step, 0);
        drive(2'd2, 2'd1, 1'b1, 0);
        tick();
        chk("r033_f1t1_00", out_patch[0][0], 10);
        chk("r033_f1t1_step", out_step, 1);
        drive(2'd2, 2'd1, 1'b0, 0);
        tick();
        chk("r033_f2t0_step", out_step, 0);
        chk("r033_f2t0_12", out_patch[1][2], 12);
        drive(2'd2, 2'd1, 1'b1, 0);
        tick();
        chk("r033_f2t1_00", out_patch[0][0], 1);
        chk("r033_f2t1_13", out_patch[1][3], 10);
        chk("r033_f2t1_step", out_step, 1);
        idle_in();
        tick();

        // Overrun: five tiles with MAX_TILES = 4 and no in_last
        for (int i = 0; i < 5; i++) begin
            drive(2'd1, 2'd1, 1'b0, 0);
            tick();
            chk("r034_step", out_step, i % 4);
            if (i == 3)
                chk("r034_no_err_yet", frame_err, 0);
        end
        chk("r034_err_set", frame_err, 1);
        chk("r034_err_tile_out", out_valid, 1);
        drive(2'd1, 2'd1, 1'b0, 0);
        tick();
        chk("r034_restart_step", out_step, 0);
        chk("r034_err_sticky", frame_err, 1);
        drive(2'd1, 2'd1, 1'b1, 0);
        tick();
        chk("r034_next_step", out_step, 1);
        idle_in();
        tick();
        chk("r034_err_still", frame_err, 1);

        // Reset while output stalled
        drive(2'd1, 2'd1, 1'b0, 0);
        tick();
        drive(2'd1, 2'd1, 1'b0, 0);
        tick();
        out_ready = 1'b0;
        #1;
        chk("r035_stalled_valid", out_valid, 1);
        chk("r035_stalled_step", out_step, 1);
        rst = 1'b1;
        drive(2'd1, 2'd1, 1'b0, 900);
        tick();
        rst = 1'b0;
        chk("r035_valid_cleared", out_valid, 0);
        chk("r035_err_cleared", frame_err, 0);
        chk("r035_step_cleared", out_step, 0);
        chk("r035_patch_cleared", out_patch[0][0], 0);
        out_ready = 1'b1;
        drive(2'd1, 2'd1, 1'b0, 0);
        #1;
        chk("r035_in_ready", in_ready, 1);
        tick();
        chk("r035_next_valid", out_valid, 1);
        chk("r035_next_step", out_step, 0);
        chk("r035_next_00", out_patch[0][0], 0);
        drive(2'd1, 2'd1, 1'b1, 0);
        tick();
        chk("r035_second_step", out_step, 1);
        chk("r035_second_00", out_patch[0][0], 10);
        idle_in();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
